usb_rx_rcu: RTL and testbench

USB_RX_RCU -- requirements
Module: usb_rx_rcu

---
 rtl/usb_rx_rcu.sv | 190 +++++++++++++++++++
 tb/tb_usb_rx_rcu.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_rcu.sv
// USB receive control unit: tracks sync, byte boundaries and EOP,
// and issues FIFO write strobes and packet status for the RX path.
module usb_rx_rcu #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       shift_enable,
    input  logic       eop,
    input  logic [7:0] rcv_data,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error,
    output logic       pkt_done
);

    localparam int BW = $clog2(MAX_BYTES + 1);
    localparam logic [BW-1:0] MAX_CNT = BW'(MAX_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        SYNC_RX,
        SETTLE,
        SYNC_CHK,
        DATA_RX,
        WRITE,
        EOP_WAIT,
        ERR_WAIT
    } state_t;

    state_t        state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [BW-1:0] byte_cnt, byte_cnt_n;
    logic [1:0]    settle_cnt, settle_cnt_n;
    logic          from_sync, from_sync_n;
    logic          eop_pend, eop_pend_n;
    logic          err_eop, err_eop_n;
    logic          rcving_n, w_enable_n, r_error_n, pkt_done_n;

    logic bit_strb, eop_strb, wrap, cnt_zone, gap_zone;

    assign bit_strb = shift_enable & ~eop;
    assign eop_strb = shift_enable & eop;
    assign wrap     = bit_strb && (bit_cnt == 3'd7);
    assign cnt_zone = (state == SYNC_RX) || (state == SETTLE) ||
                      (state == SYNC_CHK) || (state == DATA_RX) ||
                      (state == WRITE);
    assign gap_zone = (state == SETTLE) || (state == SYNC_CHK) ||
                      (state == WRITE);

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        byte_cnt_n   = byte_cnt;
        settle_cnt_n = settle_cnt;
        from_sync_n  = from_sync;
        eop_pend_n   = eop_pend;
        err_eop_n    = err_eop;
        rcving_n     = rcving;
        r_error_n    = r_error;
        w_enable_n   = 1'b0;
        pkt_done_n   = 1'b0;

        if (cnt_zone && bit_strb)
            bit_cnt_n = bit_cnt + 3'd1;
        // an EOP strobe landing between a wrap and DATA_RX is deferred
        if (gap_zone && eop_strb)
            eop_pend_n = 1'b1;

        unique case (state)
            IDLE: begin
                if (d_edge) begin
                    state_n    = SYNC_RX;
                    rcving_n   = 1'b1;
                    r_error_n  = 1'b0;
                    bit_cnt_n  = 3'd0;
                    byte_cnt_n = '0;
                    eop_pend_n = 1'b0;
                    err_eop_n  = 1'b0;
                end
            end
            SYNC_RX: begin
                if (eop_strb) begin
                    state_n   = ERR_WAIT;
                    r_error_n = 1'b1;
                    err_eop_n = 1'b1;
                end else if (wrap) begin
                    state_n      = SETTLE;
                    settle_cnt_n = 2'd0;
                    from_sync_n  = 1'b1;
                end
            end
            SETTLE: begin
                settle_cnt_n = settle_cnt + 2'd1;
                if (settle_cnt == 2'd2) begin
                    if (from_sync) begin
                        state_n = SYNC_CHK;
                    end else begin
                        state_n    = WRITE;
                        w_enable_n = (byte_cnt != MAX_CNT);
                    end
                end
            end
            SYNC_CHK: begin
                if (rcv_data == SYNC_BYTE) begin
                    state_n = DATA_RX;
                end else begin
                    state_n    = ERR_WAIT;
                    r_error_n  = 1'b1;
                    err_eop_n  = eop_pend_n;
                    eop_pend_n = 1'b0;
                end
            end
            WRITE: begin
                if (byte_cnt == MAX_CNT) begin
                    state_n    = ERR_WAIT;
                    r_error_n  = 1'b1;
                    err_eop_n  = eop_pend_n;
                    eop_pend_n = 1'b0;
                end else begin
                    state_n    = DATA_RX;
                    byte_cnt_n = byte_cnt + 1'b1;
                end
            end
            DATA_RX: begin
                if (eop_strb || eop_pend) begin
                    eop_pend_n = 1'b0;
                    if (bit_cnt == 3'd0) begin
                        state_n = EOP_WAIT;
                    end else begin
                        state_n   = ERR_WAIT;
                        r_error_n = 1'b1;
                        err_eop_n = 1'b1;
                    end
                end else if (wrap) begin
                    state_n      = SETTLE;
                    settle_cnt_n = 2'd0;
                    from_sync_n  = 1'b0;
                end
            end
            EOP_WAIT: begin
                if (bit_strb) begin
                    state_n    = IDLE;
                    rcving_n   = 1'b0;
                    pkt_done_n = 1'b1;
                end
            end
            ERR_WAIT: begin
                if (eop_strb) begin
                    err_eop_n = 1'b1;
                end else if (bit_strb && err_eop) begin
                    state_n   = IDLE;
                    rcving_n  = 1'b0;
                    err_eop_n = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            byte_cnt   <= '0;
            settle_cnt <= 2'd0;
            from_sync  <= 1'b0;
            eop_pend   <= 1'b0;
            err_eop    <= 1'b0;
            rcving     <= 1'b0;
            w_enable   <= 1'b0;
            r_error    <= 1'b0;
            pkt_done   <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            byte_cnt   <= byte_cnt_n;
            settle_cnt <= settle_cnt_n;
            from_sync  <= from_sync_n;
            eop_pend   <= eop_pend_n;
            err_eop    <= err_eop_n;
            rcving     <= rcving_n;
            w_enable   <= w_enable_n;
            r_error    <= r_error_n;
            pkt_done   <= pkt_done_n;
        end
    end

endmodule

// File: tb/tb_usb_rx_rcu.sv
// Directed bench for usb_rx_rcu: default instance plus a
// MAX_BYTES=2 instance sharing the same stimulus.
module tb_usb_rx_rcu;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       d_edge = 1'b0;
    logic       shift_enable = 1'b0;
    logic       eop = 1'b0;
    logic [7:0] rcv_data = 8'h00;
    logic       rcving, w_enable, r_error, pkt_done;
    logic       rcving2, w_enable2, r_error2, pkt_done2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_strb = 0;

    int         wen_n = 0;
    int         wen2_n = 0;
    int         pd_n = 0;
    int         pd2_n = 0;
    int         both_n = 0;
    logic       pd_rcv = 1'b1;
    logic [7:0] wdata[$];
    int         wcyc[$];

    usb_rx_rcu dut (
        .clk(clk), .n_rst(n_rst), .d_edge(d_edge),
        .shift_enable(shift_enable), .eop(eop), .rcv_data(rcv_data),
        .rcving(rcving), .w_enable(w_enable),
        .r_error(r_error), .pkt_done(pkt_done)
    );

    usb_rx_rcu #(.MAX_BYTES(2)) dut2 (
        .clk(clk), .n_rst(n_rst), .d_edge(d_edge),
        .shift_enable(shift_enable), .eop(eop), .rcv_data(rcv_data),
        .rcving(rcving2), .w_enable(w_enable2),
        .r_error(r_error2), .pkt_done(pkt_done2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (w_enable) begin
            wen_n = wen_n + 1;
            wdata.push_back(rcv_data);
            wcyc.push_back(cyc);
        end
        if (w_enable2) wen2_n = wen2_n + 1;
        if (pkt_done) begin
            pd_n = pd_n + 1;
            pd_rcv = rcving;
        end
        if (pkt_done2) pd2_n = pd2_n + 1;
        if ((w_enable && pkt_done) || (w_enable2 && pkt_done2))
            both_n = both_n + 1;
    end

    // Strobe sampled at the next edge E0; shift register shows the bit
    // after E3; returns just after E5 so strobes are 6 cycles apart.
    task automatic send_bit(input logic b, input logic e);
        shift_enable = 1'b1;
        eop = e;
        @(posedge clk); #1;
        last_strb = cyc;
        shift_enable = 1'b0;
        eop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (!e) rcv_data = {b, rcv_data[7:1]};
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i], 1'b0);
    endtask

    task automatic pulse_edge;
        d_edge = 1'b1;
        @(posedge clk); #1;
        d_edge = 1'b0;
    endtask

    task automatic test_reset;
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if ({rcving, w_enable, r_error, pkt_done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outs got %b want 0000",
                     {rcving, w_enable, r_error, pkt_done});
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rcving2, w_enable2, r_error2, pkt_done2} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outs2 got %b want 0000",
                     {rcving2, w_enable2, r_error2, pkt_done2});
        end
    endtask

    task automatic test_good;
        int w0, p0, c1, c2;
        w0 = wen_n;
        p0 = pd_n;
        pulse_edge();
        checks++;
        if (rcving !== 1'b1) begin
            errors++;
            $display("FAIL good_rcving_start got %b want 1", rcving);
        end
        send_byte(8'h80);
        pulse_edge();
        send_byte(8'hA5);
        c1 = last_strb;
        send_byte(8'hC3);
        c2 = last_strb;
        send_bit(1'b0, 1'b1);
        checks++;
        if (pd_n - p0 !== 0 || rcving !== 1'b1) begin
            errors++;
            $display("FAIL good_eop_wait got pd %0d rcv %b want 0 1",
                     pd_n - p0, rcving);
        end
        send_bit(1'b1, 1'b0);
        checks++;
        if (wen_n - w0 !== 2) begin
            errors++;
            $display("FAIL good_wen_count got %0d want 2", wen_n - w0);
        end
        if (wdata.size() >= w0 + 2) begin
            checks++;
            if (wdata[w0] !== 8'hA5 || wdata[w0+1] !== 8'hC3) begin
                errors++;
                $display("FAIL good_wdata got %h %h want a5 c3",
                         wdata[w0], wdata[w0+1]);
            end
            checks++;
            if (wcyc[w0] - c1 !== 3 || wcyc[w0+1] - c2 !== 3) begin
                errors++;
                $display("FAIL good_wen_lat got %0d %0d want 3 3",
                         wcyc[w0] - c1, wcyc[w0+1] - c2);
            end
        end
        checks++;
        if (pd_n - p0 !== 1 || pd_rcv !== 1'b0) begin
            errors++;
            $display("FAIL good_pkt_done got %0d rcv %b want 1 0",
                     pd_n - p0, pd_rcv);
        end
        checks++;
        if (r_error !== 1'b0 || rcving !== 1'b0) begin
            errors++;
            $display("FAIL good_end got err %b rcv %b want 0 0",
                     r_error, rcving);
        end
    endtask

    task automatic test_bad_sync;
        int w0, p0;
        w0 = wen_n;
        p0 = pd_n;
        pulse_edge();
        for (int i = 0; i < 7; i++) send_bit(i == 0, 1'b0);
        send_bit(1'b1, 1'b0);
        checks++;
        if (r_error !== 1'b1 || rcving !== 1'b1) begin
            errors++;
            $display("FAIL badsync_err got err %b rcv %b want 1 1",
                     r_error, rcving);
        end
        send_byte(8'hFF);
        send_bit(1'b0, 1'b1);
        checks++;
        if (rcving !== 1'b1) begin
            errors++;
            $display("FAIL badsync_hold got %b want 1", rcving);
        end
        send_bit(1'b1, 1'b0);
        checks++;
        if (rcving !== 1'b0 || r_error !== 1'b1) begin
            errors++;
            $display("FAIL badsync_end got rcv %b err %b want 0 1",
                     rcving, r_error);
        end
        checks++;
        if (wen_n - w0 !== 0 || pd_n - p0 !== 0) begin
            errors++;
            $display("FAIL badsync_pulses got wen %0d pd %0d want 0 0",
                     wen_n - w0, pd_n - p0);
        end
    endtask

    task automatic test_back_to_back;
        int w0, p0;
        w0 = wen_n;
        p0 = pd_n;
        pulse_edge();
        checks++;
        if (r_error !== 1'b0 || rcving !== 1'b1) begin
            errors++;
            $display("FAIL b2b_clear got err %b rcv %b want 0 1",
                     r_error, rcving);
        end
        send_byte(8'h80);
        send_byte(8'h11);
        send_byte(8'h22);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        checks++;
        if (wen_n - w0 !== 2 || pd_n - p0 !== 1) begin
            errors++;
            $display("FAIL b2b_pulses got wen %0d pd %0d want 2 1",
                     wen_n - w0, pd_n - p0);
        end
        if (wdata.size() >= w0 + 2) begin
            checks++;
            if (wdata[w0] !== 8'h11 || wdata[w0+1] !== 8'h22) begin
                errors++;
                $display("FAIL b2b_wdata got %h %h want 11 22",
                         wdata[w0], wdata[w0+1]);
            end
        end
        checks++;
        if (r_error !== 1'b0 || rcving !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got err %b rcv %b want 0 0",
                     r_error, rcving);
        end
    endtask

    task automatic test_eop_partial;
        int w0, p0;
        w0 = wen_n;
        p0 = pd_n;
        pulse_edge();
        send_byte(8'h80);
        send_byte(8'h5A);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        checks++;
        if (r_error !== 1'b1 || rcving !== 1'b1) begin
            errors++;
            $display("FAIL partial_err got err %b rcv %b want 1 1",
                     r_error, rcving);
        end
        send_bit(1'b1, 1'b0);
        checks++;
        if (wen_n - w0 !== 1 || pd_n - p0 !== 0) begin
            errors++;
            $display("FAIL partial_pulses got wen %0d pd %0d want 1 0",
                     wen_n - w0, pd_n - p0);
        end
        checks++;
        if (rcving !== 1'b0 || r_error !== 1'b1) begin
            errors++;
            $display("FAIL partial_end got rcv %b err %b want 0 1",
                     rcving, r_error);
        end
    endtask

    task automatic test_reset_mid;
        int w0, p0;
        pulse_edge();
        send_byte(8'h80);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        n_rst = 1'b0;
        #1;
        checks++;
        if ({rcving, w_enable, r_error, pkt_done} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_outs got %b want 0000",
                     {rcving, w_enable, r_error, pkt_done});
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        w0 = wen_n;
        p0 = pd_n;
        pulse_edge();
        send_byte(8'h80);
        send_byte(8'h96);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        checks++;
        if (wen_n - w0 !== 1 || pd_n - p0 !== 1) begin
            errors++;
            $display("FAIL midrst_pulses got wen %0d pd %0d want 1 1",
                     wen_n - w0, pd_n - p0);
        end
        if (wdata.size() >= w0 + 1) begin
            checks++;
            if (wdata[w0] !== 8'h96) begin
                errors++;
                $display("FAIL midrst_wdata got %h want 96", wdata[w0]);
            end
        end
        checks++;
        if (r_error !== 1'b0) begin
            errors++;
            $display("FAIL midrst_err got %b want 0", r_error);
        end
    endtask

    task automatic test_overflow;
        int w0, v0, p0, q0;
        w0 = wen_n;
        v0 = wen2_n;
        p0 = pd_n;
        q0 = pd2_n;
        pulse_edge();
        send_byte(8'h80);
        send_byte(8'h01);
        send_byte(8'h02);
        checks++;
        if (r_error2 !== 1'b0 || wen2_n - v0 !== 2) begin
            errors++;
            $display("FAIL ovf_two got err %b wen %0d want 0 2",
                     r_error2, wen2_n - v0);
        end
        send_byte(8'h03);
        checks++;
        if (r_error2 !== 1'b1 || wen2_n - v0 !== 2) begin
            errors++;
            $display("FAIL ovf_third got err %b wen %0d want 1 2",
                     r_error2, wen2_n - v0);
        end
        checks++;
        if (r_error !== 1'b0 || wen_n - w0 !== 3) begin
            errors++;
            $display("FAIL ovf_main got err %b wen %0d want 0 3",
                     r_error, wen_n - w0);
        end
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        checks++;
        if (rcving2 !== 1'b0 || pd2_n - q0 !== 0 || r_error2 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_end2 got rcv %b pd %0d err %b want 0 0 1",
                     rcving2, pd2_n - q0, r_error2);
        end
        checks++;
        if (pd_n - p0 !== 1) begin
            errors++;
            $display("FAIL ovf_main_pd got %0d want 1", pd_n - p0);
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_bad_sync();
        test_back_to_back();
        test_eop_partial();
        test_reset_mid();
        test_overflow();
        checks++;
        if (both_n !== 0) begin
            errors++;
            $display("FAIL wen_pd_overlap got %0d want 0", both_n);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
